// File: rtl/counter_pkg.sv
// Shared constants for the counter library: default width and count-direction codes.
package counter_pkg;
  localparam int DEFAULT_COUNTER_WIDTH = 4;
  localparam bit COUNT_UP              = 1'b0;
  localparam bit COUNT_DOWN            = 1'b1;
endpackage

// File: rtl/tff_stage.sv
// One ripple stage: rising-edge T flip-flop with asynchronous active-high reset.
module tff_stage (
  input  logic clk,
  input  logic reset,
  input  logic t,
  output logic q
);
  logic q_q;
  logic q_d;

  assign q_d = q_q ^ t;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q_q <= 1'b0;
    else       q_q <= q_d;
  end

  assign q = q_q;
endmodule

// File: rtl/ripple_up_down_counter.sv
// Ripple (asynchronous) up/down binary counter built from a chain of toggling T flip-flops.
// COUNTER_QSYNC_EN adds q_sync, a clk-domain copy of q delayed by one cycle.
module ripple_up_down_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_COUNTER_WIDTH,
  parameter bit DOWN  = COUNT_UP
) (
  output logic [WIDTH-1:0] q,
  input  logic             clk,
  input  logic             reset
`ifdef COUNTER_QSYNC_EN
  ,
  output logic [WIDTH-1:0] q_sync
`endif
);
  logic [WIDTH-1:0] stage_q;
  logic [WIDTH-1:0] stage_clk;

  assign stage_clk[0] = clk;

  // Up-counting stages toggle when the previous bit falls, so they are clocked by its inverse.
  for (genvar i = 1; i < WIDTH; i++) begin : g_clk
    if (DOWN == COUNT_DOWN) begin : g_dn
      assign stage_clk[i] = stage_q[i-1];
    end else begin : g_up
      assign stage_clk[i] = ~stage_q[i-1];
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    tff_stage u_tff (
      .clk   (stage_clk[i]),
      .reset (reset),
      .t     (1'b1),
      .q     (stage_q[i])
    );
  end

  assign q = stage_q;

`ifdef COUNTER_QSYNC_EN
  logic [WIDTH-1:0] q_sync_q;

  // Samples the value settled before this edge, giving a glitch-free copy one cycle late.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) q_sync_q <= '0;
    else       q_sync_q <= stage_q;
  end

  assign q_sync = q_sync_q;
`endif
endmodule

// File: tb/tb_ripple_up_down_counter.sv
// Bench for ripple_up_down_counter: an up and a down instance (WIDTH=4) on a shared clock and reset.
module tb_ripple_up_down_counter;
  logic       clk;
  logic       rst;
  logic [3:0] q_up;
  logic [3:0] q_dn;
`ifdef COUNTER_QSYNC_EN
  logic [3:0] qs_up;
  logic [3:0] qs_dn;
`endif

  int checks   = 0;
  int failures = 0;

  ripple_up_down_counter #(.WIDTH(4), .DOWN(1'b0)) dut_up (
    .q     (q_up),
    .clk   (clk),
    .reset (rst)
`ifdef COUNTER_QSYNC_EN
    ,
    .q_sync(qs_up)
`endif
  );

  ripple_up_down_counter #(.WIDTH(4), .DOWN(1'b1)) dut_dn (
    .q     (q_dn),
    .clk   (clk),
    .reset (rst)
`ifdef COUNTER_QSYNC_EN
    ,
    .q_sync(qs_dn)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic rst;
    int   up;
    int   dn;
    int   sync_up;
  } vec_t;

  vec_t vecs [21];

  int m_up, m_dn, m_sync_up, m_sync_dn;

  initial begin
    vecs = '{
      '{1'b0, 0, 0, 0},   '{1'b0, 1, 15, 0},  '{1'b0, 2, 14, 1},  '{1'b0, 3, 13, 2},
      '{1'b0, 4, 12, 3},  '{1'b0, 5, 11, 4},  '{1'b0, 6, 10, 5},  '{1'b0, 7, 9, 6},
      '{1'b0, 8, 8, 7},   '{1'b0, 9, 7, 8},   '{1'b0, 10, 6, 9},  '{1'b0, 11, 5, 10},
      '{1'b0, 12, 4, 11}, '{1'b0, 13, 3, 12}, '{1'b0, 14, 2, 13}, '{1'b0, 15, 1, 14},
      '{1'b0, 0, 0, 15},  '{1'b0, 1, 15, 0},  '{1'b1, 0, 0, 0},   '{1'b0, 0, 0, 0},
      '{1'b0, 1, 15, 0}
    };

    // Reset held across the first clk edge at 5 ns.
    rst = 1'b1;
    #1;
    check("reset_up", int'(q_up), 0);
    check("reset_dn", int'(q_dn), 0);
    #5;
    check("reset_edge_up", int'(q_up), 0);
    check("reset_edge_dn", int'(q_dn), 0);
`ifdef COUNTER_QSYNC_EN
    check("reset_sync", int'(qs_up), 0);
`endif

    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      rst = vecs[i].rst;
      #1;
      check($sformatf("vec%0d_up", i), int'(q_up), vecs[i].up);
      check($sformatf("vec%0d_dn", i), int'(q_dn), vecs[i].dn);
`ifdef COUNTER_QSYNC_EN
      check($sformatf("vec%0d_sync", i), int'(qs_up), vecs[i].sync_up);
`endif
    end

    // Mid-count reset between edges must clear at once, without a clk edge.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("seq_rst_up", int'(q_up), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    check("seq_six_up", int'(q_up), 6);
    check("seq_six_dn", int'(q_dn), 10);
    rst = 1'b1;
    #1;
    check("seq_async_up", int'(q_up), 0);
    check("seq_async_dn", int'(q_dn), 0);
`ifdef COUNTER_QSYNC_EN
    check("seq_async_sync", int'(qs_up), 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("seq_first_up", int'(q_up), 1);
    check("seq_first_dn", int'(q_dn), 15);

    // Random reset pulses against an edge-counting model.
    @(negedge clk);
    rst = 1'b1;
    m_up = 0; m_dn = 0; m_sync_up = 0; m_sync_dn = 0;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk);
      if (!rst) begin
        m_sync_up = m_up;
        m_sync_dn = m_dn;
        m_up = (m_up + 1) % 16;
        m_dn = (m_dn + 15) % 16;
      end
      @(negedge clk);
      rst = ($urandom_range(0, 7) == 0);
      if (rst) begin
        m_up = 0; m_dn = 0; m_sync_up = 0; m_sync_dn = 0;
      end
      #1;
      check("rand_up", int'(q_up), m_up);
      check("rand_dn", int'(q_dn), m_dn);
`ifdef COUNTER_QSYNC_EN
      check("rand_sync_up", int'(qs_up), m_sync_up);
      check("rand_sync_dn", int'(qs_dn), m_sync_dn);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ripple_up_down_counter.md
Name: ripple_up_down_counter

Overview:
- Parameterisable asynchronous (ripple) binary counter built from a chain of T flip-flops held permanently in toggle mode.
- Stage 0 is clocked by clk. Each later stage is clocked by the output of the stage before it.
- Used as a small free-running event/cycle counter. Serves as the reference ripple-counter primitive in the counter library.
- Output is not glitch-free between edges. A registered, clk-domain copy is available as an option.

Parameters:
- WIDTH, 4, number of counter bits/stages; legal range 1..32.
- DOWN, 0, count direction: 0 = up (increment), 1 = down (decrement).

Ports:
- clk  input  1  counter clock; stage 0 toggles on every rising edge.
- reset  input  1  asynchronous, active-high reset; one clock, asynchronous active-high reset named reset, clock named clk.
- q  output  WIDTH  counter value; q[0] is the LSB.
- Declaration order is q, clk, reset, so positional instantiation (q, clk, reset) is valid.

Behaviour:
- Reset
  - While reset=1: every stage is forced to 0 immediately, independent of clk; q=0 and it holds.
  - Reset deassertion is not synchronised.
  - The first count occurs on the first rising clk edge after reset falls.
  - Reset asserted mid-count (including mid-ripple) clears all stages at once; no partial value persists after reset.
- Stage 0: q[0] toggles on every rising edge of clk.
- Stage i>0, DOWN=0: q[i] toggles on the falling edge of q[i-1]. Result: q increments by 1 per clk rising edge.
- Stage i>0, DOWN=1: q[i] toggles on the rising edge of q[i-1]. Result: q decrements by 1 per clk rising edge.
- Wrap-around, modulo 2^WIDTH with no flag and no saturation:
  - up: all-ones -> 0
  - down: 0 -> all-ones
- Latency and ripple settling:
  - In zero-delay simulation q is fully settled within the same time step as the clk edge.
  - In silicon, q may pass through transient intermediate codes for up to WIDTH flip-flop delays.
  - Consumers sample q no earlier than 1 ns after a rising clk edge, or use q_sync.
- No enable or load input; the counter runs whenever reset=0.
- Each T flip-flop stage has T tied to 1 and uses the same asynchronous active-high reset.

Optional Feature:
- Macro: COUNTER_QSYNC_EN.
- Defined:
  - Adds output port q_sync [WIDTH-1:0], declared after reset.
  - q_sync is a clk-domain register that loads q on every rising clk edge; asynchronous reset to 0 by reset.
  - q_sync therefore presents the settled count one clk cycle late. Example: when q has just become 5, q_sync = 4.
  - q_sync is glitch-free.
- Not defined: port and register are absent; the module has exactly q, clk, reset.

Decomposition:
- Package counter_pkg: constant DEFAULT_COUNTER_WIDTH = 4 and constant COUNT_UP = 0 / COUNT_DOWN = 1 for the DOWN parameter.
- Sub-module tff_stage, one per bit, WIDTH instances:
  - ports clk, reset, t, q
  - rising-edge T flip-flop with async active-high reset
  - DOWN=0 stages are clocked from the inverted previous output.
- The q_sync register lives in the top module.

Test Plan:
- Reset: clk period 10 ns starting at clk=0; reset=1 for 0–10 ns -> q=0 throughout, including across the clk edge at 5 ns.
- Up count: reset falls at 10 ns (WIDTH=4, DOWN=0) -> q=1 after the edge at 15 ns, q=2 at 25 ns, ..., q=15 at 155 ns.
- Wrap: same run continued -> q=0 after the edge at 165 ns; q=4 at 210 ns (20 edges since reset).
- Mid-run reset: assert reset at 73 ns (between edges, q=6) -> q=0 immediately, no clk edge needed. Release at 90 ns -> q=1 after the 95 ns edge.
- Down count: DOWN=1, reset released -> q=15 after the first edge, then 14, 13, ...; after 16 edges q=0.
- COUNTER_QSYNC_EN defined: reset -> q_sync=0. After edges at 15/25/35 ns -> q_sync = 0/1/2 while q = 1/2/3. q_sync never shows a code other than the previous settled q.
